// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: internal pixel-rate enable, h/v raster counters,
// sync/active decode and a frame-boundary run/stop controller.
module vga_timing_controller #(
  parameter int unsigned PIX_DIV  = 3,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned DIV_W = (PIX_DIV > 0) ? $clog2(PIX_DIV + 1) : 1;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] h_step;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_nxt;
  logic [CNT_W-1:0] v_step;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic             adv_c;
  logic             h_last_c;
  logic             v_last_c;
  logic             frame_end_c;
  logic             run_nxt_c;
  logic             h_vis_c;
  logic             v_vis_c;
  logic             h_sync_c;
  logic             v_sync_c;

  logic             pix_tick_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             video_on_nxt;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             line_start_nxt;
  logic             frame_start_nxt;
  logic             busy_nxt;

  // Next-state and output decode; everything registered below is taken from
  // the post-edge counter values so outputs line up with the counters.
  always_comb begin
    div_nxt         = div_cnt + DIV_W'(1);
    adv_c           = 1'b0;
    h_last_c        = 1'b0;
    v_last_c        = 1'b0;
    frame_end_c     = 1'b0;
    h_step          = '0;
    v_step          = '0;
    state_nxt       = state;
    h_nxt           = h_cnt;
    v_nxt           = v_cnt;
    run_nxt_c       = 1'b0;
    h_vis_c         = 1'b0;
    v_vis_c         = 1'b0;
    h_sync_c        = 1'b0;
    v_sync_c        = 1'b0;
    pix_tick_nxt    = 1'b0;
    hsync_nxt       = ~SYNC_POL;
    vsync_nxt       = ~SYNC_POL;
    video_on_nxt    = 1'b0;
    x_nxt           = '0;
    y_nxt           = '0;
    line_start_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    busy_nxt        = 1'b0;

    // Free-running divider; the edge that lands on PIX_DIV starts a tick cycle.
    if (div_cnt == DIV_W'(PIX_DIV)) begin
      div_nxt = '0;
    end
    adv_c = (div_nxt == DIV_W'(PIX_DIV));

    h_last_c    = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last_c    = (v_cnt == CNT_W'(V_TOTAL - 1));
    frame_end_c = h_last_c && v_last_c;
    h_step      = h_last_c ? '0 : h_cnt + CNT_W'(1);
    if (h_last_c) begin
      v_step = v_last_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      v_step = v_cnt;
    end

    if (adv_c) begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          h_nxt = h_step;
          v_nxt = v_step;
          if (frame_end_c) begin
            if (!enable) begin
              state_nxt = ST_IDLE;
            end
          end else if (!enable) begin
            state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          h_nxt = h_step;
          v_nxt = v_step;
          if (frame_end_c) begin
            state_nxt = enable ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      endcase
    end

    run_nxt_c = (state_nxt != ST_IDLE);
    h_vis_c   = (h_nxt < CNT_W'(H_ACTIVE));
    v_vis_c   = (v_nxt < CNT_W'(V_ACTIVE));
    h_sync_c  = (h_nxt >= CNT_W'(H_SYNC_START)) && (h_nxt < CNT_W'(H_SYNC_END));
    v_sync_c  = (v_nxt >= CNT_W'(V_SYNC_START)) && (v_nxt < CNT_W'(V_SYNC_END));

    pix_tick_nxt    = adv_c;
    busy_nxt        = run_nxt_c;
    video_on_nxt    = run_nxt_c && h_vis_c && v_vis_c;
    hsync_nxt       = (run_nxt_c && h_sync_c) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt       = (run_nxt_c && v_sync_c) ? SYNC_POL : ~SYNC_POL;
    x_nxt           = video_on_nxt ? h_nxt : '0;
    y_nxt           = video_on_nxt ? v_nxt : '0;
    line_start_nxt  = adv_c && run_nxt_c && (h_nxt == '0);
    frame_start_nxt = line_start_nxt && (v_nxt == '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= ST_IDLE;
      pix_tick    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      state       <= state_nxt;
      pix_tick    <= pix_tick_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_on_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench: two instances (PIX_DIV=1 and PIX_DIV=0) compared every
// clock against a raster-position reference model, plus frame statistics.
module tb_vga_timing_controller;

  localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk;
  logic rst_n;
  logic enable;
  logic [1:0] pt, hs, vs, vo, ls, fs, bz;
  logic [1:0][11:0] xx, yy;

  vga_timing_controller #(
    .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_tick(pt[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .x(xx[0]), .y(yy[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .busy(bz[0])
  );

  vga_timing_controller #(
    .PIX_DIV(0), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_tick(pt[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .x(xx[1]), .y(yy[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  // Reference model: clocks since reset, running flag, linear pixel index.
  int n [2];
  int p [2];
  bit run [2];
  bit tk [2];

  // Measured per-frame statistics, snapshot at each observed frame_start.
  int since [2], gap [2], ls_since [2], ls_gap [2];
  int vs_acc [2], vs_f [2], vid_acc [2], vid_f [2];
  int hs_acc [2], hs_f [2], lsn_acc [2], lsn_f [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; p[i] = 0; run[i] = 1'b0; tk[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        n[i] = 0; p[i] = 0; run[i] = 1'b0; tk[i] = 1'b0;
      end else begin
        n[i]++;
        tk[i] = ((n[i] % (div_of(i) + 1)) == div_of(i));
        if (tk[i]) begin
          if (!run[i]) begin
            if (enable) begin
              run[i] = 1'b1;
              p[i] = 0;
            end
          end else if (p[i] == FRAME - 1) begin
            p[i] = 0;
            run[i] = enable;
          end else begin
            p[i]++;
          end
        end
      end
    end
  endtask

  function automatic logic [30:0] model_vec(input int i);
    int h, v;
    logic vid, hsl, vsl, lsx, fsx;
    logic [11:0] ex, ey;
    h = p[i] % HT;
    v = p[i] / HT;
    vid = run[i] && (h < HA) && (v < VA);
    hsl = run[i] && (h >= HA + HFP) && (h < HA + HFP + HS);
    vsl = run[i] && (v >= VA + VFP) && (v < VA + VFP + VS);
    lsx = tk[i] && run[i] && (h == 0);
    fsx = lsx && (v == 0);
    ex = vid ? 12'(h) : 12'd0;
    ey = vid ? 12'(v) : 12'd0;
    return {tk[i], ~hsl, ~vsl, vid, run[i], lsx, fsx, ex, ey};
  endfunction

  function automatic logic [30:0] obs_vec(input int i);
    return {pt[i], hs[i], vs[i], vo[i], bz[i], ls[i], fs[i], xx[i], yy[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stats(input int i);
    since[i]++;
    ls_since[i]++;
    if (ls[i]) begin
      ls_gap[i] = ls_since[i];
      ls_since[i] = 0;
    end
    if (fs[i]) begin
      gap[i] = since[i]; since[i] = 0;
      vs_f[i] = vs_acc[i]; vs_acc[i] = 0;
      vid_f[i] = vid_acc[i]; vid_acc[i] = 0;
      hs_f[i] = hs_acc[i]; hs_acc[i] = 0;
      lsn_f[i] = lsn_acc[i]; lsn_acc[i] = 0;
    end
    vs_acc[i] += int'(!vs[i]);
    vid_acc[i] += int'(vo[i] && pt[i]);
    hs_acc[i] += int'(!hs[i]);
    lsn_acc[i] += int'(ls[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc%0d_dut%0d", ncyc, i), {1'b0, obs_vec(i)}, {1'b0, model_vec(i)});
      stats(i);
    end
    ncyc++;
  endtask

  task automatic wait_fs(input int i, input int limit, input string tag);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!fs[i] && k < limit);
    check(tag, 32'(fs[i]), 32'd1);
  endtask

  task automatic wait_pos(input int i, input int target, input int limit, input string tag);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < limit) begin
      cycle();
      k++;
      hit = run[i] && tk[i] && (p[i] == target);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int ticks [2];
    int fs_cnt;
    int k;
    bit hit;

    for (int i = 0; i < 2; i++) begin
      since[i] = 0; gap[i] = 0; ls_since[i] = 0; ls_gap[i] = 0;
      vs_acc[i] = 0; vs_f[i] = 0; vid_acc[i] = 0; vid_f[i] = 0;
      hs_acc[i] = 0; hs_f[i] = 0; lsn_acc[i] = 0; lsn_f[i] = 0;
    end

    // Power-on reset.
    rst_n = 1'b1;
    enable = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_dut0", {1'b0, obs_vec(0)}, {1'b0, model_vec(0)});
    check("reset_dut1", {1'b0, obs_vec(1)}, {1'b0, model_vec(1)});
    repeat (3) cycle();
    #2 rst_n = 1'b1;

    // Idle with enable low: divider runs, raster outputs stay deasserted.
    ticks[0] = 0;
    ticks[1] = 0;
    repeat (40) begin
      cycle();
      ticks[0] += int'(pt[0]);
      ticks[1] += int'(pt[1]);
    end
    check("idle_ticks_div1", 32'(ticks[0]), 32'd20);
    check("idle_ticks_div0", 32'(ticks[1]), 32'd40);

    // Start running and collect full-frame statistics.
    enable = 1'b1;
    wait_fs(0, 10, "first_fs");
    check("first_fs_xy", {8'd0, xx[0], yy[0]}, 32'd0);
    repeat (300) cycle();
    check("fs_period_div1", 32'(gap[0]), 32'd96);
    check("fs_period_div0", 32'(gap[1]), 32'd48);
    check("ls_period_div1", 32'(ls_gap[0]), 32'd16);
    check("ls_period_div0", 32'(ls_gap[1]), 32'd8);
    check("vsync_low_div1", 32'(vs_f[0]), 32'd16);
    check("vsync_low_div0", 32'(vs_f[1]), 32'd8);
    check("video_ticks_div1", 32'(vid_f[0]), 32'd12);
    check("video_ticks_div0", 32'(vid_f[1]), 32'd12);
    check("hsync_low_div1", 32'(hs_f[0]), 32'd24);
    check("hsync_low_div0", 32'(hs_f[1]), 32'd12);
    check("lines_per_frame", 32'(lsn_f[0]), 32'd6);

    // Drop enable at v=1,h=2: the frame drains to the end, then idles.
    wait_pos(0, HT + 2, 200, "reach_v1h2");
    enable = 1'b0;
    fs_cnt = 0;
    k = 0;
    while (run[0] && k < 300) begin
      cycle();
      fs_cnt += int'(fs[0]);
      k++;
    end
    repeat (60) begin
      cycle();
      fs_cnt += int'(fs[0]);
    end
    check("drain_no_fs", 32'(fs_cnt), 32'd0);
    check("drain_idle_busy", 32'(bz[0]), 32'd0);

    // Enable re-asserted during a drain: next frame starts on the boundary.
    enable = 1'b1;
    wait_fs(0, 20, "restart_fs");
    wait_pos(0, 20, 200, "reach_p20");
    enable = 1'b0;
    repeat (20) cycle();
    check("drain_busy", 32'(bz[0]), 32'd1);
    enable = 1'b1;
    wait_fs(0, 200, "redrain_fs");
    check("redrain_period", 32'(gap[0]), 32'd96);

    // Asynchronous reset while vsync is asserted.
    k = 0;
    hit = 1'b0;
    while (!hit && k < 200) begin
      cycle();
      k++;
      hit = run[0] && (p[0] / HT == 4);
    end
    check("reach_v4", 32'(hit), 32'd1);
    check("v4_vsync_low", 32'(vs[0]), 32'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_vsync", 32'(vs[0]), 32'd1);
    check("rst_mid_video", 32'(vo[0]), 32'd0);
    check("rst_mid_dut0", {1'b0, obs_vec(0)}, {1'b0, model_vec(0)});
    check("rst_mid_dut1", {1'b0, obs_vec(1)}, {1'b0, model_vec(1)});
    repeat (3) cycle();
    #2 rst_n = 1'b1;
    wait_fs(0, 10, "post_rst_fs");
    check("post_rst_xy", {8'd0, xx[0], yy[0]}, 32'd0);

    // Random enable toggling, checked every clock against the model.
    repeat (1500) begin
      if ($urandom_range(99) < 2) enable = ~enable;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
Sequences VGA raster timing from the system clock. It generates a pixel-rate clock enable internally, using the same divide convention as the team's clock divider but without deriving a new clock. It steps horizontal and vertical counters through the active, front-porch, sync and back-porch phases. It drives hsync/vsync, video_on and the pixel coordinates consumed by the pixel generator. Start and stop requests take effect only on frame boundaries.

Parameters:
PIX_DIV, 3, pixel tick asserted when divide counter == PIX_DIV; tick period = PIX_DIV+1 clk cycles (100 MHz -> 25 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
enable  input  1  run request; level-sensitive, sampled at frame boundaries
pix_tick  output  1  one-clk pulse per pixel period
hsync  output  1  horizontal sync, polarity per SYNC_POL
vsync  output  1  vertical sync, polarity per SYNC_POL
video_on  output  1  high while (h,v) is inside the active region and running
x  output  12  pixel column, 0..H_ACTIVE-1 when video_on, else 0
y  output  12  pixel row, 0..V_ACTIVE-1 when video_on, else 0
line_start  output  1  one-clk pulse coincident with the pix_tick that enters h=0
frame_start  output  1  one-clk pulse coincident with the pix_tick that enters h=0,v=0
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst_n=0): div counter=0, h_cnt=0, v_cnt=0, state=IDLE. pix_tick=0, video_on=0, x=0, y=0, line_start=0, frame_start=0, busy=0. hsync and vsync are held at the deasserted level (~SYNC_POL).
- Divider: runs in every state. It counts 0..PIX_DIV, and pix_tick=1 in the cycle where count==PIX_DIV, after which the count wraps to 0. PIX_DIV=0 gives a tick every clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Phase boundaries are derived from the counters:
  - ACTIVE: h<H_ACTIVE
  - FP: next H_FP counts
  - SYNC: next H_SYNC counts
  - BP: remainder
  - The vertical axis uses the same scheme.
- Counters advance only on pix_tick in RUN/DRAIN:
  - h wraps at H_TOTAL-1 to 0.
  - v increments on the h wrap and wraps at V_TOTAL-1 to 0.
- All outputs are registered and update in the same clk edge as the counter advance. Latency from the counter reaching a value to the outputs reflecting it is 0 cycles (outputs are decoded from next-state).
- hsync = SYNC_POL while h is in the H sync phase, else ~SYNC_POL. vsync = SYNC_POL while v is in the V sync phase, regardless of h.
- Control FSM:
  - IDLE: counters held at 0, outputs deasserted. On a pix_tick with enable=1, go to RUN; that tick enters (0,0) and pulses frame_start and line_start.
  - RUN: if enable=0 at the tick that wraps v to 0, go to IDLE instead of starting a new frame (no frame_start). If enable drops mid-frame, go to DRAIN.
  - DRAIN: finish the current frame unchanged. At the end-of-frame tick, re-enter RUN if enable=1 again, else IDLE.
- Enable toggling within a frame never truncates or restarts that frame.
- Reset mid-frame: immediate return to the reset values. The next frame starts cleanly from (0,0) after reset release and enable.
- No combinational path from enable to any output.

Test Plan:
Sim params are PIX_DIV=1, H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), SYNC_POL=0.
1. Release reset with enable=0 for 40 clks -> pix_tick every 2nd clk; hsync=vsync=1; video_on=0; busy=0; x=y=0.
2. Assert enable -> next tick gives frame_start=line_start=1, video_on=1, x=0, y=0. x increments 0..3 on successive ticks; hsync=0 exactly for h=5,6 (4 clks); line_start repeats every 16 clks.
3. Full frame -> vsync=0 for exactly v=4 (8 ticks / 16 clks); video_on high for 12 ticks per frame; frame_start period = 48 ticks = 96 clks.
4. Deassert enable at v=1,h=2 -> busy stays 1, frame completes through v=5,h=7, then IDLE with no second frame_start. Re-asserting during DRAIN -> next frame starts at the normal boundary with frame_start.
5. Assert rst_n=0 at v=4 (vsync low) -> vsync=1 and video_on=0 immediately (async). After release with enable=1 -> clean frame_start at (0,0).
6. PIX_DIV=0 rerun of scenario 3 -> frame_start period = 48 clks.
